bus_arbiter_mux: RTL

Parametrised bus arbiter and master-side multiplexer for the shared SoC bus. It accepts requests from NUM_MASTERS bus masters and issues a registered one-hot grant using round-robin arbitration with an optional hold limit. It steers the granted master's address, strobe, read/write and write data onto the single slave-side bus. It sits between the masters and the address decoder / slave mux, and replaces the fixed-priority grant-driven master mux.

---
 rtl/bus_arbiter_mux.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter with optional hold limit, plus the master-to-slave
// request mux steered by the registered grant.
module bus_arbiter_mux #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int MAX_HOLD    = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [NUM_MASTERS-1:0]            m_as,
  input  logic [NUM_MASTERS-1:0]            m_rw,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_wr_data,
  output logic [NUM_MASTERS-1:0]            m_grnt,
  output logic [$clog2(NUM_MASTERS)-1:0]    grnt_id,
  output logic                              grnt_vld,
  output logic [ADDR_W-1:0]                 s_addr,
  output logic                              s_as,
  output logic                              s_rw,
  output logic [DATA_W-1:0]                 s_wr_data
);

  localparam int ID_W   = $clog2(NUM_MASTERS);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]             state_reg, state_next;
  logic [ID_W-1:0]        owner_reg, owner_next;
  logic [ID_W-1:0]        last_reg, last_next;
  logic [HOLD_W-1:0]      hold_reg, hold_next;
  logic [NUM_MASTERS-1:0] grnt_reg, grnt_next;

  logic [ADDR_W-1:0] addr_arr [NUM_MASTERS];
  logic [DATA_W-1:0] data_arr [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] cand;
  logic                   win_found;
  logic [ID_W-1:0]        win_id;
  logic                   owner_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi]  = m_wr_data[gi*DATA_W +: DATA_W];
      assign grnt_next[gi] = (state_next == OWNED) && (owner_next == ID_W'(gi));
    end
  endgenerate

  // The current owner never competes in its own search, so one search
  // serves both hold-limit rotation and release handover.
  always_comb begin
    cand = m_req;
    if (state_reg == OWNED) begin
      cand[owner_reg] = 1'b0;
    end
  end

  always_comb begin
    int pos;
    pos       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      pos = (int'(last_reg) + k) % NUM_MASTERS;
      if (!win_found && cand[pos]) begin
        win_found = 1'b1;
        win_id    = ID_W'(pos);
      end
    end
  end

  assign owner_req = m_req[owner_reg];

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        owner_next = '0;
        hold_next  = '0;
        if (win_found) begin
          state_next = OWNED;
          owner_next = win_id;
          last_next  = win_id;
        end
      end
      default: begin
        if (owner_req) begin
          if ((MAX_HOLD > 0) && (hold_reg == HOLD_LAST) && win_found) begin
            owner_next = win_id;
            last_next  = win_id;
            hold_next  = '0;
          end else if ((MAX_HOLD > 0) && (hold_reg != HOLD_LAST)) begin
            hold_next = hold_reg + 1'b1;
          end
        end else if (win_found) begin
          owner_next = win_id;
          last_next  = win_id;
          hold_next  = '0;
        end else begin
          state_next = IDLE;
          owner_next = '0;
          hold_next  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= ID_W'(NUM_MASTERS - 1);
      hold_reg  <= '0;
      grnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
      grnt_reg  <= grnt_next;
    end
  end

  assign m_grnt   = grnt_reg;
  assign grnt_id  = owner_reg;
  assign grnt_vld = (state_reg == OWNED);

  // Single mux level from master inputs; idle bus parks as a read with no strobe.
  always_comb begin
    s_addr    = '0;
    s_as      = 1'b0;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (state_reg == OWNED) begin
      s_addr    = addr_arr[owner_reg];
      s_as      = m_as[owner_reg];
      s_rw      = m_rw[owner_reg];
      s_wr_data = data_arr[owner_reg];
    end
  end

endmodule
